// File: rtl/settings_menu_nav.sv
// rtl/settings_menu_nav.sv - settings menu open/close FSM with hovered-option navigation and hold-to-repeat
module settings_menu_nav #(
   parameter int NUM_OPTIONS  = 4,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 6_250_000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [9:0] key_is_pressed,
   input  logic       menu_open,
   output logic [2:0] hovered_idx,
   output logic       menu_active,
   output logic       menu_done
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [2:0]    LAST_IDX  = 3'(NUM_OPTIONS - 1);
   localparam logic [2:0]    NONE_IDX  = 3'd7;
   localparam logic [CW-1:0] DELAY_END = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_END  = CW'(REPEAT_RATE - 1);

   localparam int KEY_UP   = 8;
   localparam int KEY_DOWN = 2;
   localparam int KEY_CONF = 5;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   typedef enum logic {PH_DELAY, PH_RATE} phase_t;

   state_t          state;
   phase_t          phase;
   logic [CW-1:0]   cnt;
   logic [9:0]      key_prev;
   logic            open_prev;

   logic [9:0]      press;
   logic            open_rise;
   logic            up_held;
   logic            down_held;
   logic            one_dir;
   logic            dir_edge;
   logic            repeat_hit;
   logic [2:0]      idx_up;
   logic [2:0]      idx_down;
   logic [2:0]      idx_step;

   // A key held before it is sampled here never counts as a press.
   assign press      = key_is_pressed & ~key_prev;
   assign open_rise  = menu_open & ~open_prev;
   assign up_held    = key_is_pressed[KEY_UP];
   assign down_held  = key_is_pressed[KEY_DOWN];
   assign one_dir    = up_held ^ down_held;
   assign dir_edge   = up_held ? press[KEY_UP] : press[KEY_DOWN];
   assign repeat_hit = (phase == PH_RATE) ? (cnt == RATE_END) : (cnt == DELAY_END);

   // Wrapping neighbours of the hovered option; with one option both stay at 0.
   assign idx_up   = (hovered_idx == 3'd0) ? LAST_IDX : hovered_idx - 3'd1;
   assign idx_down = (hovered_idx == LAST_IDX) ? 3'd0 : hovered_idx + 3'd1;
   assign idx_step = up_held ? idx_up : idx_down;

   // Menu FSM, edge history and auto-repeat timer with registered outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         phase       <= PH_DELAY;
         cnt         <= '0;
         key_prev    <= '0;
         open_prev   <= 1'b0;
         hovered_idx <= NONE_IDX;
         menu_active <= 1'b0;
         menu_done   <= 1'b0;
      end else begin
         key_prev  <= key_is_pressed;
         open_prev <= menu_open;
         menu_done <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               phase <= PH_DELAY;
               if (open_rise) begin
                  state       <= ACTIVE;
                  hovered_idx <= 3'd0;
                  menu_active <= 1'b1;
               end
            end
            ACTIVE: begin
               if (press[KEY_CONF]) begin
                  // Confirm beats any navigation sampled on the same edge.
                  state       <= DONE;
                  menu_done   <= 1'b1;
                  menu_active <= 1'b0;
                  hovered_idx <= NONE_IDX;
                  cnt         <= '0;
                  phase       <= PH_DELAY;
               end else if (!one_dir) begin
                  cnt   <= '0;
                  phase <= PH_DELAY;
               end else if (dir_edge) begin
                  hovered_idx <= idx_step;
                  cnt         <= '0;
                  phase       <= PH_DELAY;
               end else if (repeat_hit) begin
                  hovered_idx <= idx_step;
                  cnt         <= '0;
                  phase       <= PH_RATE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
               phase <= PH_DELAY;
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               phase       <= PH_DELAY;
               hovered_idx <= NONE_IDX;
               menu_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_settings_menu_nav.sv
// tb/tb_settings_menu_nav.sv - directed and randomized checks of settings_menu_nav against a rule-level model
module tb_settings_menu_nav;

   localparam int N = 4;
   localparam int D = 8;
   localparam int R = 3;

   localparam logic [9:0] UP = 10'h100;
   localparam logic [9:0] DN = 10'h004;
   localparam logic [9:0] CF = 10'h020;
   localparam logic [9:0] NONE = 10'h000;

   logic       clk = 1'b0;
   logic       resetN;
   logic [9:0] key_is_pressed;
   logic       menu_open;
   logic [2:0] hovered_idx;
   logic       menu_active;
   logic       menu_done;

   int tests = 0;
   int fails = 0;

   // Model state: what the outputs should be after each sampled edge.
   int         m_idx;
   bit         m_active;
   bit         m_done;
   bit         m_closing;
   int         m_run;
   logic [9:0] m_pk;
   logic       m_pmo;

   always #5 clk = ~clk;

   settings_menu_nav #(
      .NUM_OPTIONS  (N),
      .REPEAT_DELAY (D),
      .REPEAT_RATE  (R)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .key_is_pressed (key_is_pressed),
      .menu_open      (menu_open),
      .hovered_idx    (hovered_idx),
      .menu_active    (menu_active),
      .menu_done      (menu_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_idx     = 7;
      m_active  = 0;
      m_done    = 0;
      m_closing = 0;
      m_run     = 0;
      m_pk      = '0;
      m_pmo     = 1'b0;
   endtask

   task automatic model_move(input bit up);
      if (up) m_idx = (m_idx + N - 1) % N;
      else    m_idx = (m_idx + 1) % N;
   endtask

   // m_run counts cycles a single direction has been held since its last fresh
   // press (or since the last break in the hold); steps land on the press
   // itself, at D, and every R after that.
   task automatic model_edge(input logic [9:0] k, input logic mo);
      logic [9:0] e;
      bit up, dn;
      e  = k & ~m_pk;
      up = k[8];
      dn = k[2];
      if (m_closing) begin
         m_closing = 0;
         m_done    = 0;
         m_idx     = 7;
         m_active  = 0;
         m_run     = 0;
      end else if (!m_active) begin
         m_done = 0;
         m_run  = 0;
         if (mo && !m_pmo) begin
            m_active = 1;
            m_idx    = 0;
         end
      end else if (e[5]) begin
         m_active  = 0;
         m_idx     = 7;
         m_done    = 1;
         m_closing = 1;
         m_run     = 0;
      end else if (up == dn) begin
         m_run = 0;
      end else if (up ? e[8] : e[2]) begin
         m_run = 0;
         model_move(up);
      end else begin
         m_run++;
         if (m_run == D || (m_run > D && (m_run - D) % R == 0)) model_move(up);
      end
      m_pk  = k;
      m_pmo = mo;
   endtask

   task automatic check_outs(input string tag);
      check_eq({tag, "_idx"},    32'(hovered_idx), 32'(m_idx));
      check_eq({tag, "_active"}, 32'(menu_active), 32'(m_active));
      check_eq({tag, "_done"},   32'(menu_done),   32'(m_done));
   endtask

   task automatic tick(input logic [9:0] k, input logic mo, input string tag);
      key_is_pressed = k;
      menu_open      = mo;
      @(posedge clk);
      model_edge(k, mo);
      #1;
      check_outs(tag);
   endtask

   logic [9:0] rk;
   logic       rmo;

   initial begin
      resetN         = 1'b0;
      key_is_pressed = '0;
      menu_open      = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_idx", 32'(hovered_idx), 32'd7);
      check_eq("rst_active", 32'(menu_active), 32'd0);
      check_eq("rst_done", 32'(menu_done), 32'd0);
      #2 resetN = 1'b1;

      // Closed menu ignores navigation.
      for (int i = 0; i < 5; i++) tick((i % 2 == 0) ? UP : DN, 1'b0, "idle");
      tick(NONE, 1'b0, "idle");
      check_eq("idle_idx", 32'(hovered_idx), 32'd7);

      // Open and single taps with wrap.
      tick(NONE, 1'b1, "open");
      check_eq("open_idx", 32'(hovered_idx), 32'd0);
      check_eq("open_active", 32'(menu_active), 32'd1);
      tick(NONE, 1'b0, "gap");
      tick(UP, 1'b0, "up_wrap");
      check_eq("up_wrap_idx", 32'(hovered_idx), 32'd3);
      tick(NONE, 1'b0, "gap");
      tick(DN, 1'b0, "dn_wrap");
      check_eq("dn_wrap_idx", 32'(hovered_idx), 32'd0);
      tick(NONE, 1'b0, "gap");
      tick(DN, 1'b0, "dn_tap");
      check_eq("dn_tap_idx", 32'(hovered_idx), 32'd1);
      tick(NONE, 1'b0, "gap");
      tick(UP, 1'b0, "up_tap");
      tick(NONE, 1'b0, "gap");

      // Hold down from 0: delay then repeat rate.
      for (int i = 1; i <= 20; i++) begin
         tick(DN, 1'b0, "hold");
         if (i == 1)  check_eq("hold_t1",  32'(hovered_idx), 32'd1);
         if (i == 8)  check_eq("hold_t8",  32'(hovered_idx), 32'd1);
         if (i == 9)  check_eq("hold_t9",  32'(hovered_idx), 32'd2);
         if (i == 12) check_eq("hold_t12", 32'(hovered_idx), 32'd3);
         if (i == 15) check_eq("hold_t15", 32'(hovered_idx), 32'd0);
         if (i == 18) check_eq("hold_t18", 32'(hovered_idx), 32'd1);
      end
      tick(NONE, 1'b0, "release");
      check_eq("release_idx", 32'(hovered_idx), 32'd1);
      tick(DN, 1'b0, "to2");
      tick(NONE, 1'b0, "gap");

      // Both directions held: no movement; then up alone without a fresh edge.
      for (int i = 0; i < 15; i++) tick(UP | DN, 1'b0, "both");
      check_eq("both_idx", 32'(hovered_idx), 32'd2);
      for (int i = 0; i < 3; i++) tick(UP, 1'b0, "up_stale");
      check_eq("up_stale_idx", 32'(hovered_idx), 32'd2);
      tick(NONE, 1'b0, "gap");
      tick(UP, 1'b0, "to1");
      tick(NONE, 1'b0, "gap");

      // Confirm with down on the same edge: close, no step.
      tick(CF | DN, 1'b0, "confirm");
      check_eq("confirm_done", 32'(menu_done), 32'd1);
      check_eq("confirm_idx", 32'(hovered_idx), 32'd7);
      tick(NONE, 1'b0, "after_done");
      check_eq("after_done", 32'(menu_done), 32'd0);
      tick(NONE, 1'b1, "reopen");
      check_eq("reopen_idx", 32'(hovered_idx), 32'd0);
      tick(NONE, 1'b0, "gap");
      tick(CF, 1'b0, "close2");
      tick(NONE, 1'b0, "gap");

      // Down held across the open: no immediate step, then hold into repeat.
      tick(DN, 1'b0, "pre_hold");
      tick(DN, 1'b1, "open_held");
      check_eq("open_held_idx", 32'(hovered_idx), 32'd0);
      for (int i = 0; i < 10; i++) tick(DN, 1'b0, "held_open");

      // Asynchronous reset between edges while repeating.
      #2 resetN = 1'b0;
      #1;
      model_reset();
      check_outs("arst");
      check_eq("arst_idx", 32'(hovered_idx), 32'd7);
      #1 resetN = 1'b1;
      for (int i = 0; i < 3; i++) tick(DN, 1'b0, "post_rst");
      tick(DN, 1'b1, "open_after_rst");
      for (int i = 0; i < 3; i++) tick(DN, 1'b0, "no_edge");
      check_eq("no_edge_idx", 32'(hovered_idx), 32'd0);
      tick(NONE, 1'b0, "gap");

      // Randomized held-key traffic.
      rk = '0;
      for (int i = 0; i < 2000; i++) begin
         rk[8] = rk[8] ^ ($urandom_range(0, 9) == 0);
         rk[2] = rk[2] ^ ($urandom_range(0, 9) == 0);
         rk[5] = rk[5] ^ ($urandom_range(0, 29) == 0);
         rk    = (rk & 10'h124) | (10'($urandom) & ~10'h124);
         rmo   = ($urandom_range(0, 19) == 0);
         tick(rk, rmo, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
